// File: rtl/imm_gen_if.sv
// Handshake bundle between fetch and the immediate generator / downstream
// stage. The slave modport is the imm_gen_pipe view; master is the
// producer/consumer view (fetch drives in_*, execute drives out_ready).
interface imm_gen_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [TAGW-1:0] out_tag;

  modport master (
    output flush, in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for the decode stage.
// Decodes the format from the opcode, sign-extends the immediate to XLEN
// and carries the PC/tag alongside it. One output register (main) plus a
// one-entry skid register give full throughput with a registered in_ready.
// Optional feature macro: IMM_GEN_ZICSR_EN (CSR-immediate Z format for
// SYSTEM opcodes with funct3 101/110/111).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until accepted;
// out_* stay stable while out_valid=1 and out_ready=0. in_ready depends only
// on registered state, never combinationally on out_ready.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input logic   clk,
  input logic   rst_n,
  imm_gen_if.slave bus
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] FMT_Z    = 3'b101;
`endif
  localparam logic [2:0] FMT_NONE = 3'b111;

  // Decoded view of the incoming instruction
  logic [6:0]      op;
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  // Storage
  logic            main_valid, skid_valid, rdy_q;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [2:0]      main_fmt, skid_fmt;
  logic            main_ill, skid_ill;
  logic [TAGW-1:0] main_tag, skid_tag;

  // Datapath control
  logic in_fire, out_fire;
  logic load_main, load_skid, skid_to_main;
  logic skid_valid_nxt, main_valid_nxt;

  assign op = bus.in_inst[6:0];

  // Opcode -> format and 32-bit immediate; Z-format values have bit 31 clear,
  // so one sign extension serves every format.
  always_comb begin
    imm32   = 32'd0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0001111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
        if (bus.in_inst[14:12] == 3'b101 || bus.in_inst[14:12] == 3'b110 ||
            bus.in_inst[14:12] == 3'b111) begin
          dec_fmt = FMT_Z;
          imm32   = {27'd0, bus.in_inst[19:15]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
        end
`else
        dec_fmt = FMT_I;
        imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
`endif
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                   bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {bus.in_inst[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                   bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_fmt = FMT_NONE;
        dec_ill = 1'b1;
      end
    endcase
    dec_imm = XLEN'($signed(imm32));
  end

  // Movement between input, main and skid; skid full implies in_ready=0,
  // so a skid->main move never coincides with an accepted input.
  always_comb begin
    in_fire        = bus.in_valid & rdy_q;
    out_fire       = main_valid & bus.out_ready;
    load_main      = in_fire & (~main_valid | out_fire);
    load_skid      = in_fire & main_valid & ~out_fire;
    skid_to_main   = out_fire & skid_valid;
    skid_valid_nxt = load_skid | (skid_valid & ~skid_to_main);
    main_valid_nxt = load_main | skid_to_main | (main_valid & ~out_fire);
  end

  // State update: reset beats flush, flush beats all data movement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b0;
      main_imm   <= '0;
      main_fmt   <= FMT_NONE;
      main_ill   <= 1'b0;
      main_tag   <= '0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_ill   <= 1'b0;
      skid_tag   <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      rdy_q      <= ~skid_valid_nxt;
      if (load_main) begin
        main_imm <= dec_imm;
        main_fmt <= dec_fmt;
        main_ill <= dec_ill;
        main_tag <= bus.in_tag;
      end else if (skid_to_main) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_ill <= skid_ill;
        main_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_ill <= dec_ill;
        skid_tag <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_illegal = main_ill;
  assign bus.out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with the
// same stimulus and checks both against a queue-based reference model.
module tb_imm_gen_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'd0, in_tag = 32'd0;

  imm_gen_if #(.XLEN(32), .TAGW(32)) b32 ();
  imm_gen_if #(.XLEN(64), .TAGW(32)) b64 ();

  assign b32.flush = flush;  assign b64.flush = flush;
  assign b32.in_valid = in_valid;  assign b64.in_valid = in_valid;
  assign b32.in_inst = in_inst;  assign b64.in_inst = in_inst;
  assign b32.in_tag = in_tag;  assign b64.in_tag = in_tag;
  assign b32.out_ready = out_ready;  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAGW(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAGW(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_dec(input logic [31:0] i, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint v;
    v = 0; fmt = 3'b111; ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: begin
        fmt = 3'd0; v = longint'(i[31:20]); if (i[31]) v -= 4096;
      end
      7'h23: begin
        fmt = 3'd1; v = longint'({i[31:25], i[11:7]}); if (i[31]) v -= 4096;
      end
      7'h63: begin
        fmt = 3'd2; v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); if (i[31]) v -= 8192;
      end
      7'h37, 7'h17: begin
        fmt = 3'd3; v = longint'({i[31:12], 12'd0}); if (i[31]) v -= 64'h1_0000_0000;
      end
      7'h6F: begin
        fmt = 3'd4; v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); if (i[31]) v -= 2097152;
      end
      7'h33, 7'h3B: fmt = 3'b111;
      default: ill = 1'b1;
    endcase
`ifdef IMM_GEN_ZICSR_EN
    if (i[6:0] == 7'h73 && i[14:12] >= 3'd5) begin
      fmt = 3'd5; v = longint'(i[19:15]);
    end
`endif
    imm = v;
  endfunction

  // Entries in flight, oldest first: {tag, inst}
  logic [63:0] exp_q[$];
  logic        m_ready = 1'b0;
  logic        m_fi, m_fo;

  // Model: a 2-deep FIFO; ready means fewer than two entries held.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_ready = 1'b1;
    end else begin
      m_fi = in_valid && m_ready;
      m_fo = (exp_q.size() > 0) && out_ready;
      if (m_fo) void'(exp_q.pop_front());
      if (m_fi) exp_q.push_back({in_tag, in_inst});
      m_ready = exp_q.size() < 2;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic        chk_en = 1'b0;
  logic [63:0] e_imm;
  logic [2:0]  e_fmt;
  logic        e_ill;
  logic [63:0] head;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready32", 64'(b32.in_ready), 64'(m_ready));
      chk("in_ready64", 64'(b64.in_ready), 64'(m_ready));
      chk("out_valid32", 64'(b32.out_valid), 64'(exp_q.size() > 0));
      chk("out_valid64", 64'(b64.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        ref_dec(head[31:0], e_imm, e_fmt, e_ill);
        chk("imm32", 64'(b32.out_imm), 64'(e_imm[31:0]));
        chk("imm64", b64.out_imm, e_imm);
        chk("fmt32", 64'(b32.out_fmt), 64'(e_fmt));
        chk("fmt64", 64'(b64.out_fmt), 64'(e_fmt));
        chk("ill32", 64'(b32.out_illegal), 64'(e_ill));
        chk("ill64", 64'(b64.out_illegal), 64'(e_ill));
        chk("tag32", 64'(b32.out_tag), 64'(head[63:32]));
        chk("tag64", 64'(b64.out_tag), 64'(head[63:32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1 from an empty pipe; it is
  // visible on out_* at the next sample point.
  task automatic send(input logic [31:0] inst, input logic [31:0] tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = inst;
    in_tag    = tag;
    next_cyc();
    in_valid  = 1'b0;
  endtask

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 9) r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  logic [31:0] got [$];
  logic [95:0] got_pk;
  logic        acc, pending;

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) next_cyc();
    chk_en = 1'b1;
    // reset values while rst_n=0
    chk("rst_imm32", 64'(b32.out_imm), 64'd0);
    chk("rst_fmt32", 64'(b32.out_fmt), 64'd7);
    rst_n = 1'b1;
    next_cyc();
    chk("ready_after_rst", 64'(b32.in_ready), 64'd1);

    // Directed formats
    send(32'hFFF00093, 32'h100);
    chk("i_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
    chk("i_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_fmt", 64'(b32.out_fmt), 64'd0);
    chk("i_ill", 64'(b32.out_illegal), 64'd0);
    chk("i_tag", 64'(b32.out_tag), 64'h100);
    send(32'h800000B7, 32'h104);
    chk("u_imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("u_imm32", 64'(b32.out_imm), 64'h8000_0000);
    chk("u_fmt", 64'(b64.out_fmt), 64'd3);
    send(32'hFE512E23, 32'h108);
    chk("s_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
    chk("s_fmt", 64'(b32.out_fmt), 64'd1);
    send(32'hFE000CE3, 32'h10C);
    chk("b_imm", 64'(b32.out_imm), 64'hFFFF_FFF8);
    chk("b_fmt", 64'(b32.out_fmt), 64'd2);
    send(32'h001000EF, 32'h110);
    chk("j_imm", 64'(b32.out_imm), 64'h0000_0800);
    chk("j_fmt", 64'(b32.out_fmt), 64'd4);
    send(32'h0000007F, 32'h114);
    chk("ill_fmt", 64'(b32.out_fmt), 64'd7);
    chk("ill_ill", 64'(b32.out_illegal), 64'd1);
    chk("ill_imm", 64'(b32.out_imm), 64'd0);
    send(32'h00208033, 32'h118);
    chk("r_fmt", 64'(b32.out_fmt), 64'd7);
    chk("r_ill", 64'(b32.out_illegal), 64'd0);
    send(32'h300FD073, 32'h11C);
`ifdef IMM_GEN_ZICSR_EN
    chk("z_imm", 64'(b32.out_imm), 64'h1F);
    chk("z_imm64", b64.out_imm, 64'h1F);
    chk("z_fmt", 64'(b32.out_fmt), 64'd5);
`else
    chk("z_imm", 64'(b32.out_imm), 64'h300);
    chk("z_imm64", b64.out_imm, 64'h300);
    chk("z_fmt", 64'(b32.out_fmt), 64'd0);
`endif
    next_cyc();

    // Back-pressure: tags 1,2,3 back-to-back with out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 32'd1;
    next_cyc();
    in_inst = 32'h00200093; in_tag = 32'd2;
    next_cyc();
    chk("bp_ready_low", 64'(b32.in_ready), 64'd0);
    in_inst = 32'h00300093; in_tag = 32'd3;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      chk("bp_stall_tag", 64'(b32.out_tag), 64'd1);
      chk("bp_stall_imm", 64'(b32.out_imm), 64'd1);
    end
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (b32.out_valid) got.push_back(b32.out_tag);
      acc = in_valid && m_ready;
      next_cyc();
      if (acc) in_valid = 1'b0;
    end
    got_pk = '0;
    for (int k = 0; k < got.size() && k < 3; k++) got_pk[95 - 32*k -: 32] = got[k];
    chk("bp_count", 64'(got.size()), 64'd3);
    chk("bp_order_hi", got_pk[95:32], 64'h0000_0001_0000_0002);
    chk("bp_order_lo", 64'(got_pk[31:0]), 64'd3);

    // Flush with main and skid full, plus a new entry offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h01100093; in_tag = 32'h11;
    next_cyc();
    in_tag = 32'h12;
    next_cyc();
    flush = 1'b1; in_tag = 32'h13;
    next_cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_ready", 64'(b32.in_ready), 64'd1);
    out_ready = 1'b1;
    next_cyc();
    chk("fl_nodeliver", 64'(b32.out_valid), 64'd0);

    // Flush with only main full while an entry actually fires
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'h21;
    next_cyc();
    flush = 1'b1; in_tag = 32'h22;
    next_cyc();
    flush = 1'b0; in_valid = 1'b0;
    next_cyc();
    chk("fl2_discard", 64'(b64.out_valid), 64'd0);

    // Reset mid-operation
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h31;
    next_cyc();
    in_tag = 32'h32;
    next_cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    next_cyc();
    chk("mr_valid", 64'(b64.out_valid), 64'd0);
    chk("mr_ready", 64'(b64.in_ready), 64'd0);
    chk("mr_imm", b64.out_imm, 64'd0);
    chk("mr_fmt", 64'(b64.out_fmt), 64'd7);
    chk("mr_ill", 64'(b64.out_illegal), 64'd0);
    chk("mr_tag", 64'(b64.out_tag), 64'd0);
    rst_n = 1'b1;
    next_cyc();
    chk("mr_ready_rel", 64'(b64.in_ready), 64'd1);

    // Randomized traffic
    pending = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_inst  = rand_inst();
        in_tag   = $urandom;
      end
      flush     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      pending   = in_valid && !m_ready && !flush;
      next_cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) next_cyc();
    chk("drained", 64'(b32.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Format is decoded from the opcode, so no external format select is needed.
- Covers all base RV formats: I, S, B, U and J.
- Sign-extends the immediate to XLEN and carries a PC/tag alongside it.
- Registered output with a valid/ready handshake, a 1-entry skid buffer and a flush; sits between fetch and the register-read/execute stage.

Parameters:
- XLEN, 32, output immediate width; legal values are 32 or 64.
- TAGW, 32, width of the tag (PC) carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  in_inst/in_tag are valid.
- in_ready  output  1  block can accept an entry this cycle.
- in_inst  input  32  raw instruction.
- in_tag  input  TAGW  PC/tag of the instruction.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_imm  output  XLEN  sign/zero-extended immediate.
- out_fmt  output  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 111 none.
- out_illegal  output  1  opcode unrecognised.
- out_tag  output  TAGW  tag passed through unchanged.

Behaviour:
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency is 1 cycle: an entry accepted on edge N is presented on out_* after edge N.
- Storage: one output register (main) plus one skid register (skid).
  - in_ready = !skid_valid, driven from a register and never combinational from out_ready.
  - in_fire while main is empty, or while main is firing, loads main.
  - in_fire while main is full and not firing loads skid.
  - out_fire with skid full moves skid to main.
- Ordering: strictly FIFO; no entry is dropped or duplicated under any out_ready pattern.
- out_* fields are stable while out_valid=1 and out_ready=0.
- Opcode decode on in_inst[6:0]:
  - I format: 0000011, 0010011, 0011011, 1100111, 0001111, 1110011.
  - S format: 0100011.
  - B format: 1100011.
  - U format: 0110111, 0010111.
  - J format: 1101111.
  - fmt=111, imm=0, illegal=0: 0110011, 0111011.
  - Any other opcode: fmt=111, imm=0, illegal=1.
- Immediate values (s = in_inst[31], sign-extended from the top bit shown up to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; bit 0 is included and the value is not pre-shifted.
  - U: {inst[31:12], 12'b0}, sign-extended at XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- Every bit of out_imm is driven in every format; there are no latches.
- Flush:
  - On an edge with flush=1, main_valid and skid_valid clear.
  - An in_fire in the same cycle is discarded.
  - flush has priority over all data movement.
- Reset (rst_n=0 at an edge):
  - out_valid=0, skid_valid=0, out_imm=0, out_fmt=111, out_illegal=0, out_tag=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
  - Reset has priority over flush; an entry in flight is lost.
- Simultaneous events:
  - in_fire + out_fire with skid empty: main is replaced, out_valid stays 1.
  - in_fire + out_fire with skid full: impossible, because in_ready=0.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined:
  - Opcode 1110011 with funct3 (inst[14:12]) in {101, 110, 111} decodes as fmt=101 (Z).
  - out_imm = zero-extended inst[19:15].
  - Other SYSTEM funct3 values remain I format.
- Undefined:
  - All 1110011 instructions decode as I format.
  - fmt 101 is never produced.

Test Plan:
- Basic I format, both widths:
  - XLEN=32: 0xFFF00093 -> one cycle later out_imm=0xFFFFFFFF, fmt=000, illegal=0, tag echoed.
  - XLEN=64: lui 0x800000B7 -> out_imm=0xFFFFFFFF80000000, fmt=011.
- S/B/J sign handling:
  - 0xFE512E23 -> out_imm=0xFFFFFFFC, fmt=001.
  - 0xFE000CE3 -> out_imm=0xFFFFFFF8, fmt=010.
  - 0x001000EF -> out_imm=0x00000800, fmt=100.
- Back-pressure: hold out_ready=0 and present tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2.
  - Tag 3 is held off.
  - Raise out_ready: output order is 1,2,3; out_* stay stable during the stall.
- Illegal and R-type:
  - 0x0000007F -> fmt=111, illegal=1, imm=0.
  - 0x00208033 -> fmt=111, illegal=0.
- Flush and reset mid-operation: fill main and skid, then assert flush together with in_valid.
  - Next cycle out_valid=0, in_ready=1, and the new entry is not delivered.
  - Repeat with rst_n=0: all outputs take their reset values.
- Macro check with 0x300FD073:
  - IMM_GEN_ZICSR_EN defined -> out_imm=0x0000001F, fmt=101.
  - Undefined -> out_imm=0x00000300, fmt=000.
